latch_arbiter: RTL and testbench
================================

LATCH_ARBITER -- requirements
Module: latch_arbiter

Interface
REQ-001 The block SHALL have a parameter SETUP_CYC, default 1, giving the number of cycles lat_d is stable with lat_c low before the enable pulse; legal range 0..15.
REQ-002 The block SHALL have a parameter PULSE_CYC, default 2, giving the number of cycles lat_c is held high; legal range 1..15.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have port req, input, 4 bits: per-requester write request, held until the matching ack.
REQ-007 The block SHALL have port din, input, 32 bits: requester i data on din[8i+7:8i].
REQ-008 The block SHALL have port gnt, output, 4 bits: one-hot current owner, all zero when idle.
REQ-009 The block SHALL have port ack, output, 4 bits: one-cycle completion pulse to the owner.
REQ-010 The block SHALL have port lat_c, output, 1 bit: enable to the shared 8-bit level-sensitive latch.
REQ-011 The block SHALL have port lat_d, output, 8 bits: data to the shared latch.
REQ-012 The block SHALL have port shadow_q, output, 8 bits: copy of the last value written to the latch.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 All outputs SHALL be registered; the FSM states SHALL be IDLE, SETUP, PULSE and HOLD.
REQ-015 IDLE with req==0 SHALL remain in IDLE with gnt=0, lat_c=0 and lat_d holding its last value.
REQ-016 IDLE with any req bit set SHALL, at the same edge, select one winner, capture its din byte into lat_d, set gnt to its one-hot code and enter SETUP, or enter PULSE directly if SETUP_CYC=0.
REQ-017 SETUP SHALL hold lat_c=0 for exactly SETUP_CYC cycles, then enter PULSE.
REQ-018 PULSE SHALL drive lat_c=1 for exactly PULSE_CYC cycles, then enter HOLD.
REQ-019 HOLD SHALL last one cycle with lat_c=0, lat_d unchanged, ack[owner]=1 and shadow_q=lat_d; it SHALL then return to IDLE with gnt cleared.
REQ-020 lat_d and gnt SHALL NOT change between leaving IDLE and returning to IDLE.
REQ-021 lat_c SHALL never be high outside PULSE, and lat_d SHALL never change while lat_c is high.
REQ-022 Latency from req being sampled in IDLE to ack high SHALL be 1+SETUP_CYC+PULSE_CYC cycles (defaults: ack high in the 4th cycle after the sampling edge).
REQ-023 Deasserting req after the grant SHALL NOT abort the transaction; the captured byte is still written and ack still pulses.
REQ-024 Requests that arrive or change while busy=1 SHALL be ignored until the next IDLE.
REQ-025 A req bit still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-026 Changes to din after capture SHALL have no effect on the transaction in progress.
REQ-027 At most one gnt bit and at most one ack bit SHALL be high in any cycle.

Reset
REQ-028 With rst_n=0 at a clock edge, the FSM SHALL enter IDLE and gnt, ack, lat_c and busy SHALL be 0.
REQ-029 With rst_n=0 at a clock edge, lat_d and shadow_q SHALL be 8'h00 and the round-robin pointer SHALL select requester 0 as highest priority.
REQ-030 Reset during SETUP, PULSE or HOLD SHALL abort the transaction with no ack and with lat_c low from the next cycle.

Configuration
REQ-031 With macro LATCH_ARB_RR_EN defined, arbitration SHALL be round-robin: after an ack to requester k, priority order becomes k+1, k+2, k+3, k (mod 4).
REQ-032 With LATCH_ARB_RR_EN undefined, arbitration SHALL be fixed priority with req[0] highest and req[3] lowest, and no pointer state SHALL exist.

Verification
REQ-033 Single write: reset, then req=4'b0100 and din[23:16]=8'hA5 -> gnt=4'b0100, lat_c high for 2 cycles with lat_d=8'hA5, ack=4'b0100 4 cycles after sampling, shadow_q=8'hA5.
REQ-034 Simultaneous requests: req=4'b1111 held, din bytes 11/22/33/44 -> with RR_EN, grants in order 0,1,2,3,0 and latch writes 11,22,33,44,11; without RR_EN, requester 0 only.
REQ-035 Early drop: req[1] pulsed for 1 cycle with din[15:8]=8'h3C, then din changed to 8'hFF -> write of 8'h3C completes and ack[1] pulses.
REQ-036 Mid-operation reset: rst_n low during PULSE -> lat_c=0 the next cycle, no ack, shadow_q=8'h00, and the next request is served normally.
REQ-037 Parameter sweep SETUP_CYC=0, PULSE_CYC=1 -> lat_c high exactly 1 cycle, ack 2 cycles after sampling, and lat_d stable throughout.

Source files
------------

// File: rtl/latch_arbiter.sv
// Four-requester arbiter that writes one byte into a shared level-sensitive latch
// with setup, enable-pulse and hold phases. Define LATCH_ARB_RR_EN for round-robin arbitration.
module latch_arbiter #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] din,
  output logic [3:0]  gnt,
  output logic [3:0]  ack,
  output logic        lat_c,
  output logic [7:0]  lat_d,
  output logic [7:0]  shadow_q,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] PULSE = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYC - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic [3:0] ack_q, ack_d;
  logic       lat_c_q, lat_c_d;
  logic [7:0] lat_d_q, lat_d_d;
  logic [7:0] shadow_d;
  logic       busy_q, busy_d;
  logic [1:0] win_idx;
  logic       win_vld;

`ifdef LATCH_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cand;
  logic [1:0] own_idx;

  // Search starts at the pointer and wraps, so the last owner ends up lowest.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign own_idx = {gnt_q[3] | gnt_q[2], gnt_q[3] | gnt_q[1]};

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == HOLD) ptr_d = own_idx + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!win_vld && req[i]) begin
        win_vld = 1'b1;
        win_idx = 2'(i);
      end
    end
  end
`endif

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    lat_c_d  = 1'b0;
    lat_d_d  = lat_d_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          gnt_d   = 4'b0001 << win_idx;
          lat_d_d = din[{win_idx, 3'b000} +: 8];
          if (SETUP_CYC == 0) begin
            state_d = PULSE;
            cnt_d   = PULSE_LAST;
            lat_c_d = 1'b1;
          end else begin
            state_d = SETUP;
            cnt_d   = SETUP_LAST;
          end
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = PULSE;
          cnt_d   = PULSE_LAST;
          lat_c_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d  = HOLD;
          ack_d    = gnt_q;
          shadow_d = lat_d_q;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          lat_c_d = 1'b1;
        end
      end
      HOLD: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // NOTE: reset is sampled on the clock edge only, so it sits inside the edge-triggered block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      lat_c_q  <= 1'b0;
      lat_d_q  <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      lat_c_q  <= lat_c_d;
      lat_d_q  <= lat_d_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign lat_c = lat_c_q;
  assign lat_d = lat_d_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_latch_arbiter.sv
// Bench for latch_arbiter: vector table, directed corner sequences and a randomized
// run against a transaction-timeline model, on default and SETUP_CYC=0/PULSE_CYC=1 instances.
module tb_latch_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  gnt0, ack0, gnt1, ack1;
  logic        latc0, latc1, busy0, busy1;
  logic [7:0]  latd0, latd1, shad0, shad1;

  int n_checks = 0;
  int n_fail   = 0;

  latch_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt0), .ack(ack0), .lat_c(latc0), .lat_d(latd0),
    .shadow_q(shad0), .busy(busy0)
  );

  latch_arbiter #(.SETUP_CYC(0), .PULSE_CYC(1)) dut01 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt1), .ack(ack1), .lat_c(latc1), .lat_d(latd1),
    .shadow_q(shad1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    din   = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // ---------------- timeline reference model ----------------
  // t counts cycles since the sampling edge: 1..S setup, S+1..S+P pulse, S+P+1 hold, 0 idle.
  int         mt[2], mown[2], mptr[2];
  logic [7:0] mlatd[2], mshad[2];
  int         ps[2] = '{1, 0};
  int         pp[2] = '{2, 1};

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        mt[m] = 0; mlatd[m] = 8'h00; mshad[m] = 8'h00; mptr[m] = 0;
      end else if (mt[m] == 0) begin
        if (req != 4'h0) begin
          int w;
          w = -1;
          for (int k = 0; k < 4; k++) begin
            int c;
            c = (mptr[m] + k) % 4;
            if (w < 0 && req[c]) w = c;
          end
          mown[m]  = w;
          mlatd[m] = 8'((din >> (8 * w)) & 32'hFF);
          mt[m]    = 1;
        end
      end else if (mt[m] == ps[m] + pp[m] + 1) begin
        mt[m] = 0;
      end else begin
        mt[m]++;
        if (mt[m] == ps[m] + pp[m] + 1) begin
          mshad[m] = mlatd[m];
`ifdef LATCH_ARB_RR_EN
          mptr[m] = (mown[m] + 1) % 4;
`endif
        end
      end
    end
  endtask

  task automatic model_cmp(input int m);
    logic [3:0] eg, ea;
    logic       ec;
    eg = (mt[m] != 0) ? 4'(1 << mown[m]) : 4'h0;
    ea = (mt[m] == ps[m] + pp[m] + 1) ? eg : 4'h0;
    ec = (mt[m] >= ps[m] + 1) && (mt[m] <= ps[m] + pp[m]);
    check($sformatf("rnd%0d_gnt", m),    (m == 0) ? gnt0  : gnt1,  eg);
    check($sformatf("rnd%0d_ack", m),    (m == 0) ? ack0  : ack1,  ea);
    check($sformatf("rnd%0d_lat_c", m),  (m == 0) ? latc0 : latc1, ec);
    check($sformatf("rnd%0d_lat_d", m),  (m == 0) ? latd0 : latd1, mlatd[m]);
    check($sformatf("rnd%0d_shadow", m), (m == 0) ? shad0 : shad1, mshad[m]);
    check($sformatf("rnd%0d_busy", m),   (m == 0) ? busy0 : busy1, mt[m] != 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        lat_c;
    logic [7:0]  lat_d;
    logic [7:0]  shadow;
    logic        busy;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int k;
    logic [3:0] eg;
    logic [7:0] eb;

    tbl[0] = '{1'b0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[2] = '{1'b1, 4'h4, 32'h00A5_0000, 4'h4, 4'h0, 1'b0, 8'hA5, 8'h00, 1'b1};
    tbl[3] = '{1'b1, 4'h4, 32'h0000_0000, 4'h4, 4'h0, 1'b1, 8'hA5, 8'h00, 1'b1};
    tbl[4] = '{1'b1, 4'h4, 32'h1234_5678, 4'h4, 4'h0, 1'b1, 8'hA5, 8'h00, 1'b1};
    tbl[5] = '{1'b1, 4'h0, 32'h0000_0000, 4'h4, 4'h4, 1'b0, 8'hA5, 8'hA5, 1'b1};
    tbl[6] = '{1'b1, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 1'b0, 8'hA5, 8'hA5, 1'b0};
    tbl[7] = '{1'b1, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 1'b0, 8'hA5, 8'hA5, 1'b0};

    rst_n = 1'b0;
    req   = '0;
    din   = '0;
    @(negedge clk);

    // Single write through all phases, starting from reset.
    for (int i = 0; i < 8; i++) begin
      rst_n = tbl[i].rst_n;
      req   = tbl[i].req;
      din   = tbl[i].din;
      cyc();
      check($sformatf("vec%0d_gnt", i),    gnt0,  tbl[i].gnt);
      check($sformatf("vec%0d_ack", i),    ack0,  tbl[i].ack);
      check($sformatf("vec%0d_lat_c", i),  latc0, tbl[i].lat_c);
      check($sformatf("vec%0d_lat_d", i),  latd0, tbl[i].lat_d);
      check($sformatf("vec%0d_shadow", i), shad0, tbl[i].shadow);
      check($sformatf("vec%0d_busy", i),   busy0, tbl[i].busy);
    end

    // Simultaneous requests held high: grant order depends on the arbitration mode.
    do_reset();
    req = 4'hF;
    din = 32'h4433_2211;
    for (int n = 0; n < 5; n++) begin
`ifdef LATCH_ARB_RR_EN
      eg = 4'(1 << (n % 4));
      eb = 8'(8'h11 * ((n % 4) + 1));
`else
      eg = 4'h1;
      eb = 8'h11;
`endif
      for (k = 0; k < 20 && gnt0 == 4'h0; k++) cyc();
      check($sformatf("all_grant%0d_seen", n), k < 20, 1'b1);
      check($sformatf("all_grant%0d_gnt", n),   gnt0,  eg);
      check($sformatf("all_grant%0d_lat_d", n), latd0, eb);
      for (k = 0; k < 20 && ack0 == 4'h0; k++) cyc();
      check($sformatf("all_ack%0d_seen", n),   k < 20, 1'b1);
      check($sformatf("all_ack%0d_ack", n),    ack0,  eg);
      check($sformatf("all_ack%0d_shadow", n), shad0, eb);
      cyc();
      check($sformatf("all_idle%0d_gnt", n), gnt0, 4'h0);
    end

    // Request dropped after one cycle and din changed: captured byte still written.
    do_reset();
    req = 4'b0010;
    din = 32'h0000_3C00;
    cyc();
    check("drop_gnt", gnt0, 4'b0010);
    check("drop_lat_d_cap", latd0, 8'h3C);
    req = 4'b0000;
    din = 32'h0000_FF00;
    cyc();
    check("drop_lat_c", latc0, 1'b1);
    check("drop_lat_d_pulse", latd0, 8'h3C);
    cyc();
    cyc();
    check("drop_ack", ack0, 4'b0010);
    check("drop_shadow", shad0, 8'h3C);
    cyc();
    check("drop_idle_gnt", gnt0, 4'h0);
    check("drop_idle_busy", busy0, 1'b0);
    check("drop_idle_ack", ack0, 4'h0);

    // Reset while the latch enable is high aborts the write.
    do_reset();
    req = 4'b0001;
    din = 32'h0000_005A;
    cyc();
    cyc();
    check("mrst_pulse_lat_c", latc0, 1'b1);
    rst_n = 1'b0;
    cyc();
    check("mrst_lat_c", latc0, 1'b0);
    check("mrst_ack", ack0, 4'h0);
    check("mrst_shadow", shad0, 8'h00);
    check("mrst_lat_d", latd0, 8'h00);
    check("mrst_busy", busy0, 1'b0);
    rst_n = 1'b1;
    din   = 32'h0000_0077;
    for (k = 0; k < 10 && ack0 == 4'h0; k++) cyc();
    check("mrst_next_ack_seen", k < 10, 1'b1);
    check("mrst_next_ack", ack0, 4'b0001);
    check("mrst_next_shadow", shad0, 8'h77);

    // Zero setup, single-cycle pulse instance.
    do_reset();
    req = 4'b1000;
    din = 32'hC300_0000;
    cyc();
    check("sw_pulse_lat_c", latc1, 1'b1);
    check("sw_pulse_gnt", gnt1, 4'b1000);
    check("sw_pulse_lat_d", latd1, 8'hC3);
    check("sw_pulse_ack", ack1, 4'h0);
    req = 4'b0000;
    din = 32'h0000_0000;
    cyc();
    check("sw_hold_lat_c", latc1, 1'b0);
    check("sw_hold_ack", ack1, 4'b1000);
    check("sw_hold_lat_d", latd1, 8'hC3);
    check("sw_hold_shadow", shad1, 8'hC3);
    cyc();
    check("sw_idle_gnt", gnt1, 4'h0);
    check("sw_idle_ack", ack1, 4'h0);

    // Randomized run against the timeline model on both instances.
    for (int c = 0; c < 400; c++) begin
      rst_n = (c == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      req   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      din   = $urandom;
      model_step();
      cyc();
      model_cmp(0);
      model_cmp(1);
      check("rnd_onehot_gnt", $countones(gnt0) <= 1 && $countones(gnt1) <= 1, 1'b1);
      check("rnd_onehot_ack", $countones(ack0) <= 1 && $countones(ack1) <= 1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
